// File: rtl/stream_demux.sv
// 1-to-N stream demultiplexer with valid/ready handshake. Each output channel
// has a one-entry register, so a stalled consumer only blocks words addressed to it.
module stream_demux #(
  parameter int W     = 4,
  parameter int N_OUT = 4,
  parameter int CNT_W = 8,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [N_OUT*W-1:0]   out_data,
  output logic [N_OUT-1:0]     out_valid,
  input  logic [N_OUT-1:0]     out_ready,
  output logic [CNT_W-1:0]     drop_count
);

  localparam logic [SEL_W:0] N_LIM = (SEL_W+1)'(N_OUT);

  logic             in_range;
  logic             acc;
  logic [N_OUT-1:0] blocked;
  logic [N_OUT-1:0] full;
  logic [CNT_W-1:0] drop_reg;
  logic [CNT_W-1:0] drop_next;

  assign in_range = ({1'b0, in_sel} < N_LIM);
  // Only the addressed channel can stall the input; a draining slot passes through.
  assign in_ready = !rst && !(|blocked);
  assign acc      = in_valid && in_ready;

  generate
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_ch
      logic [W-1:0] slot_reg;
      logic [W-1:0] slot_next;
      logic         full_reg;
      logic         full_next;
      logic         sel_hit;
      logic         pop;
      logic         load;

      assign sel_hit     = (in_sel == SEL_W'(gi));
      assign pop         = full_reg && out_ready[gi];
      assign load        = acc && sel_hit;
      assign blocked[gi] = sel_hit && full_reg && !out_ready[gi];

      always_comb begin
        slot_next = slot_reg;
        full_next = full_reg && !pop;
        if (load) begin
          slot_next = in_data;
          full_next = 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          slot_reg <= '0;
          full_reg <= 1'b0;
        end else begin
          slot_reg <= slot_next;
          full_reg <= full_next;
        end
      end

      assign full[gi]             = full_reg;
      assign out_data[gi*W +: W]  = slot_reg;
    end
  endgenerate

  assign out_valid = full;

  // Out-of-range words are accepted and discarded; the counter saturates.
  always_comb begin
    drop_next = drop_reg;
    if (acc && !in_range && (drop_reg != {CNT_W{1'b1}}))
      drop_next = drop_reg + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) drop_reg <= '0;
    else     drop_reg <= drop_next;
  end

  assign drop_count = drop_reg;

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: directed scenarios plus a randomized run,
// all compared against per-channel queues that model the channel behaviour.
module tb_stream_demux;
  localparam int W = 4;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [W-1:0]   in_data;
  logic [1:0]     in_sel;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready;
  logic [7:0]     drop_count;

  logic [W-1:0]   in_data3;
  logic [1:0]     in_sel3;
  logic           in_valid3;
  logic           in_ready3;
  logic [3*W-1:0] out_data3;
  logic [2:0]     out_valid3;
  logic [2:0]     out_ready3;
  logic [1:0]     drop_count3;

  stream_demux #(.W(W), .N_OUT(N), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .drop_count(drop_count)
  );

  stream_demux #(.W(W), .N_OUT(3), .CNT_W(2)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_sel(in_sel3), .in_valid(in_valid3),
    .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready3), .drop_count(drop_count3)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: each channel is a queue of capacity one.
  logic [W-1:0] mq[N][$];

  function automatic logic model_ready();
    if (rst) return 1'b0;
    return (mq[in_sel].size() == 0) || out_ready[in_sel];
  endfunction

  function automatic logic [N-1:0] model_valid();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = (mq[k].size() != 0);
    return v;
  endfunction

  task automatic tick();
    logic acc;
    acc = in_valid && model_ready();
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < N; k++) mq[k].delete();
    end else begin
      for (int k = 0; k < N; k++)
        if (mq[k].size() != 0 && out_ready[k]) void'(mq[k].pop_front());
      if (acc) mq[in_sel].push_back(in_data);
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                       input logic [N-1:0] r);
    in_valid = v; in_sel = s; in_data = d; out_ready = r;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 2'd1, 4'hA, 4'b0000);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (in_ready !== 1'b0) begin
        failures++; $display("FAIL reset_in_ready cyc=%0d got=%b exp=0", i, in_ready);
      end
      tick();
    end
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++; $display("FAIL reset_out_valid got=%b exp=0000", out_valid);
    end
    checks++;
    if (drop_count !== 8'd0 || drop_count3 !== 2'd0) begin
      failures++; $display("FAIL reset_drop got=%0d/%0d exp=0/0", drop_count, drop_count3);
    end
    rst = 1'b0;
    drive(1'b0, 2'd0, 4'h0, 4'b1111);
    $display("reset: done");
  endtask

  task automatic test_route();
    logic [W-1:0] w;
    for (int k = 0; k < N; k++) begin
      w = 4'b1100 | W'(k);
      drive(1'b1, 2'(k), w, 4'b1111);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++; $display("FAIL route_ready k=%0d got=%b exp=1", k, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== (4'b0001 << k) || out_data[k*W +: W] !== w) begin
        failures++;
        $display("FAIL route k=%0d got valid=%b data=%h exp valid=%b data=%h",
                 k, out_valid, out_data[k*W +: W], 4'b0001 << k, w);
      end
      $display("route: sel=%0d data=%h", k, w);
    end
    drive(1'b0, 2'd0, 4'h0, 4'b1111);
    tick();
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++; $display("FAIL route_drain got=%b exp=0000", out_valid);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 2'd2, 4'h5, 4'b1011);
    tick();
    drive(1'b1, 2'd2, 4'h9, 4'b1011);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL stall_block got=%b exp=0", in_ready);
    end
    tick();
    checks++;
    if (out_valid[2] !== 1'b1 || out_data[2*W +: W] !== 4'h5) begin
      failures++; $display("FAIL stall_hold got valid=%b data=%h exp valid=1 data=5",
                           out_valid[2], out_data[2*W +: W]);
    end
    drive(1'b1, 2'd1, 4'h3, 4'b1011);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL stall_other_ready got=%b exp=1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 4'b0110 || out_data[1*W +: W] !== 4'h3 || out_data[2*W +: W] !== 4'h5) begin
      failures++; $display("FAIL stall_other got valid=%b data=%h exp valid=0110 data=h53.",
                           out_valid, out_data);
    end
    drive(1'b1, 2'd2, 4'h9, 4'b1111);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL stall_passthru_ready got=%b exp=1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 4'b0100 || out_data[2*W +: W] !== 4'h9) begin
      failures++; $display("FAIL stall_swap got valid=%b data=%h exp valid=0100 data=9",
                           out_valid, out_data[2*W +: W]);
    end
    drive(1'b0, 2'd0, 4'h0, 4'b1111);
    tick();
    $display("stall: done");
  endtask

  task automatic test_throughput();
    logic [W-1:0] w;
    for (int i = 0; i < 8; i++) begin
      w = W'($urandom);
      drive(1'b1, 2'd3, w, 4'b1000);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++; $display("FAIL thru_ready i=%0d got=%b exp=1", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid[3] !== 1'b1 || out_data[3*W +: W] !== w) begin
        failures++; $display("FAIL thru_data i=%0d got valid=%b data=%h exp valid=1 data=%h",
                             i, out_valid[3], out_data[3*W +: W], w);
      end
      $display("throughput: i=%0d data=%h", i, w);
    end
    drive(1'b0, 2'd0, 4'h0, 4'b1111);
    tick();
  endtask

  task automatic test_random();
    int errs;
    logic exp_rdy;
    logic [N-1:0] ev;
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 3) != 0), 2'($urandom), W'($urandom), N'($urandom));
      exp_rdy = model_ready();
      checks++;
      if (in_ready !== exp_rdy) begin
        failures++; errs++;
        $display("FAIL rand_ready i=%0d got=%b exp=%b", i, in_ready, exp_rdy);
      end
      tick();
      ev = model_valid();
      checks++;
      if (out_valid !== ev) begin
        failures++; errs++;
        $display("FAIL rand_valid i=%0d got=%b exp=%b", i, out_valid, ev);
      end
      for (int k = 0; k < N; k++) begin
        if (ev[k]) begin
          checks++;
          if (out_data[k*W +: W] !== mq[k][0]) begin
            failures++; errs++;
            $display("FAIL rand_data i=%0d ch=%0d got=%h exp=%h", i, k, out_data[k*W +: W], mq[k][0]);
          end
        end
      end
    end
    checks++;
    if (drop_count !== 8'd0) begin
      failures++; $display("FAIL rand_drop got=%0d exp=0", drop_count);
    end
    $display("random: 300 cycles, errors=%0d", errs);
    drive(1'b0, 2'd0, 4'h0, 4'b1111);
    tick();
  endtask

  task automatic test_drop();
    logic [1:0] exp_cnt;
    for (int i = 0; i < 5; i++) begin
      in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = W'($urandom); out_ready3 = 3'b111;
      #1;
      checks++;
      if (in_ready3 !== 1'b1) begin
        failures++; $display("FAIL drop_ready i=%0d got=%b exp=1", i, in_ready3);
      end
      tick();
      exp_cnt = (i + 1 > 3) ? 2'd3 : 2'(i + 1);
      checks++;
      if (drop_count3 !== exp_cnt || out_valid3 !== 3'b000) begin
        failures++; $display("FAIL drop i=%0d got cnt=%0d valid=%b exp cnt=%0d valid=000",
                             i, drop_count3, out_valid3, exp_cnt);
      end
      $display("drop: i=%0d count=%0d", i, drop_count3);
    end
    in_valid3 = 1'b0;
  endtask

  task automatic test_reset_midop();
    drive(1'b1, 2'd0, 4'h7, 4'b0000);
    tick();
    drive(1'b1, 2'd1, 4'h8, 4'b0000);
    tick();
    checks++;
    if (out_valid !== 4'b0011) begin
      failures++; $display("FAIL midop_fill got=%b exp=0011", out_valid);
    end
    rst = 1'b1;
    drive(1'b1, 2'd0, 4'hE, 4'b0000);
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 4'b0000 || out_data !== '0) begin
      failures++; $display("FAIL midop_reset got valid=%b data=%h exp valid=0000 data=0000",
                           out_valid, out_data);
    end
    drive(1'b1, 2'd0, 4'h6, 4'b0000);
    tick();
    checks++;
    if (out_valid !== 4'b0001 || out_data[W-1:0] !== 4'h6) begin
      failures++; $display("FAIL midop_next got valid=%b data=%h exp valid=0001 data=6",
                           out_valid, out_data[W-1:0]);
    end
    drive(1'b0, 2'd0, 4'h0, 4'b1111);
    tick();
    $display("reset_midop: done");
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    in_valid3 = 1'b0; in_sel3 = '0; in_data3 = '0; out_ready3 = '0;
    @(posedge clk); #1;
    test_reset();
    test_route();
    test_stall();
    test_throughput();
    test_random();
    test_drop();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
